// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the arb_mux_n registered N:1 selector.
package arb_mux_pkg;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} arb_state_t;

  // Index width for ch channels, never narrower than one bit.
  function automatic int sel_w(int ch);
    int w;
    w = $clog2(ch);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/arb_mux_n_rr_picker.sv
// Combinational rotating priority picker: the first request at or after ptr wins.
module rr_picker
  import arb_mux_pkg::*;
#(
  parameter  int CH    = 4,
  localparam int SEL_W = sel_w(CH)
) (
  input  logic [CH-1:0]    req,
  input  logic [SEL_W-1:0] ptr,
  output logic [CH-1:0]    gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  logic [CH-1:0] rot;
  logic          found;
  int            off;
  int            g;

  always_comb begin
    rot   = '0;
    found = 1'b0;
    off   = 0;
    g     = 0;
    // Rotate so ptr lands at bit 0; the wrap is explicit because CH need not be a power of two.
    for (int i = 0; i < CH; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= CH) j = j - CH;
      rot[i] = req[j];
    end
    for (int i = 0; i < CH; i++) begin
      if (rot[i] && !found) begin
        found = 1'b1;
        off   = i;
      end
    end
    g = int'(ptr) + off;
    if (g >= CH) g = g - CH;
  end

  assign gnt_idx    = SEL_W'(g);
  assign gnt_onehot = found ? (CH'(1) << g) : '0;
  assign any        = found;

endmodule

// File: rtl/arb_mux_n.sv
// N-channel registered selector with valid/ready on both sides and round-robin arbitration.
// Define ARB_MUX_FIXED_PRIO_EN for fixed priority (lowest valid index wins, no pointer state).
module arb_mux_n
  import arb_mux_pkg::*;
#(
  parameter int BUS = 4,
  parameter int CH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CH*BUS-1:0]      in_data,
  input  logic [CH-1:0]          in_valid,
  output logic [CH-1:0]          in_ready,
  output logic [BUS-1:0]         out_data,
  output logic [sel_w(CH)-1:0]   out_sel,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int SEL_W = sel_w(CH);

  arb_state_t       state_q, state_d;
  logic [BUS-1:0]   data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr;
  logic [CH-1:0]    gnt_onehot;
  logic [SEL_W-1:0] gnt_idx;
  logic             any;
  logic             load_ok;
  logic             accept;

  rr_picker #(.CH(CH)) u_picker (
    .req        (in_valid),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  assign load_ok  = (state_q == EMPTY) || out_ready;
  assign accept   = load_ok && any && !rst;
  assign in_ready = accept ? gnt_onehot : '0;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (accept) begin
      state_d = FULL;
      data_d  = in_data[gnt_idx*BUS +: BUS];
      sel_d   = gnt_idx;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

`ifdef ARB_MUX_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  // Pointer moves only on an accept, so idle cycles keep the priority order.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (gnt_idx == SEL_W'(CH-1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign ptr = rr_ptr_q;
`endif

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = (state_q == FULL);

endmodule

// File: tb/tb_arb_mux_n.sv
// Scoreboard bench for arb_mux_n: accepts are predicted by a reference model, queued, and checked after the edge.
module tb_arb_mux_n;

  localparam int BUS   = 4;
  localparam int CH    = 4;
  localparam int SEL_W = 2;

  logic              clk;
  logic              rst;
  logic [CH*BUS-1:0] in_data;
  logic [CH-1:0]     in_valid;
  logic [CH-1:0]     in_ready;
  logic [BUS-1:0]    out_data;
  logic [SEL_W-1:0]  out_sel;
  logic              out_valid;
  logic              out_ready;

  arb_mux_n #(.BUS(BUS), .CH(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [BUS-1:0]   data;
  } word_t;

  word_t q_exp[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // Reference model state
  logic             m_full;
  logic [BUS-1:0]   m_data;
  logic [SEL_W-1:0] m_sel;
  int               m_ptr;
  int               sel_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [CH-1:0] v, input int p);
    for (int k = 0; k < CH; k++) if (v[(p + k) % CH]) return (p + k) % CH;
    return -1;
  endfunction

  task automatic set_d(input int c, input logic [BUS-1:0] d);
    in_data[c*BUS +: BUS] = d;
  endtask

  // One clock: drive, check in_ready before the edge, check outputs after it.
  task automatic step(input logic [CH-1:0] v, input logic ordy);
    int          g;
    logic        acc;
    logic [CH-1:0] exp_rdy;
    word_t       w;
    in_valid  = v;
    out_ready = ordy;
    #3;
    g       = pick(v, m_ptr);
    acc     = (!m_full || ordy) && (g >= 0);
    exp_rdy = acc ? (CH'(1) << g) : '0;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (acc) begin
      w.sel  = SEL_W'(g);
      w.data = in_data[g*BUS +: BUS];
      q_exp.push_back(w);
    end
    @(posedge clk);
    #1;
    if (acc) begin
      m_full = 1'b1;
      m_data = w.data;
      m_sel  = w.sel;
`ifndef ARB_MUX_FIXED_PRIO_EN
      m_ptr  = (g == CH-1) ? 0 : g + 1;
`endif
      w = q_exp.pop_front();
      chk("out_data", 32'(out_data), 32'(w.data));
      chk("out_sel", 32'(out_sel), 32'(w.sel));
      sel_log.push_back(int'(out_sel));
    end else begin
      if (m_full && ordy) m_full = 1'b0;
      chk("hold_data", 32'(out_data), 32'(m_data));
      chk("hold_sel", 32'(out_sel), 32'(m_sel));
    end
    chk("out_valid", 32'(out_valid), 32'(m_full));
    chk("sel_range", 32'(int'(out_sel) < CH), 32'd1);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = '1;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #3;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    in_valid = '0;
    m_full = 1'b0; m_data = '0; m_sel = '0; m_ptr = 0;
    q_exp.delete();
    sel_log.delete();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; out_ready = 1'b1; in_data = '0;
    m_full = 1'b0; m_data = '0; m_sel = '0; m_ptr = 0;
    @(posedge clk); #1;

    // Reset with all channels requesting
    do_reset();

    // Single channel
    set_d(2, 4'b1100);
    step(4'b0100, 1'b1);
    chk("single_sel", 32'(out_sel), 32'd2);
    chk("single_data", 32'(out_data), 32'b1100);
    step(4'b0000, 1'b1);

    // Round robin with all channels held valid
    do_reset();
    set_d(0, 4'b1111); set_d(1, 4'b1010); set_d(2, 4'b1100); set_d(3, 4'b0011);
    for (int k = 0; k < 5; k++) step(4'b1111, 1'b1);
`ifndef ARB_MUX_FIXED_PRIO_EN
    chk("rr_seq", 32'({sel_log[0][1:0], sel_log[1][1:0], sel_log[2][1:0], sel_log[3][1:0], sel_log[4][1:0]}),
        32'({2'd0, 2'd1, 2'd2, 2'd3, 2'd0}));
    chk("rr_last_data", 32'(out_data), 32'b1111);
`else
    chk("fixed_seq", 32'({sel_log[0][1:0], sel_log[4][1:0]}), 32'({2'd0, 2'd0}));
`endif

    // Backpressure after first accept, then resume
    do_reset();
    step(4'b1111, 1'b1);
    for (int k = 0; k < 3; k++) step(4'b1111, 1'b0);
    chk("bp_frozen_sel", 32'(out_sel), 32'd0);
    step(4'b1111, 1'b1);
`ifndef ARB_MUX_FIXED_PRIO_EN
    chk("bp_resume_sel", 32'(out_sel), 32'd1);
`endif

    // Skip and wrap: continue to sel 2, then only channels 0/1
    step(4'b1111, 1'b1);
    step(4'b0011, 1'b1);
    step(4'b0011, 1'b1);
`ifndef ARB_MUX_FIXED_PRIO_EN
    chk("wrap_sel", 32'(out_sel), 32'd1);
`endif
    step(4'b0000, 1'b1);
    chk("drain_valid", 32'(out_valid), 32'd0);
    step(4'b0000, 1'b1);

    // Fixed-priority sanity (round-robin build rotates instead)
    do_reset();
    for (int k = 0; k < 4; k++) step(4'b1110, 1'b1);
`ifdef ARB_MUX_FIXED_PRIO_EN
    chk("fixed_sel", 32'(out_sel), 32'd1);
`endif

    // Reset mid-transfer drops the pending word
    step(4'b1111, 1'b0);
    do_reset();

    // Random traffic
    for (int k = 0; k < 200; k++) begin
      for (int c = 0; c < CH; c++) if (!in_valid[c] || in_ready[c]) set_d(c, BUS'($urandom));
      step(CH'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
